// File: rtl/game_ctrl.sv
// game_ctrl: game state, saturating score and optional hiscore (SF_HISCORE_EN).
module game_ctrl #(
  parameter int SPR_CNT      = 5,
  parameter int SCOREW       = 8,
  parameter int DEATH_FRAMES = 120
) (
  input  logic               clk_pix,
  input  logic               rst_n,
  input  logic               frame,
  input  logic               start,
  input  logic               collide,
  input  logic [SPR_CNT-1:0] land,
  output logic [1:0]         state,
  output logic               play,
  output logic               dead,
  output logic [SCOREW-1:0]  score,
  output logic [SCOREW-1:0]  hiscore,
  output logic               new_hi
);
  localparam int CW = $clog2(DEATH_FRAMES + 1);
  localparam int PW = $clog2(SPR_CNT + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DYING = 2'd2, OVER = 2'd3} st_t;
  st_t               r_state, w_nxt;
  logic              r_start_q, r_arm, r_play, r_dead;
  logic [CW-1:0]     r_cnt;
  logic [SCOREW-1:0] r_score, w_sat;
  logic [SCOREW:0]   w_sum;
  logic [PW-1:0]     w_pop;
  logic              w_press, w_go, w_die;
  // r_arm blocks a start level held across reset from counting as a press
  assign w_press = start & ~r_start_q & r_arm;
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < SPR_CNT; i++) w_pop = w_pop + PW'(land[i]);
  end
  assign w_sum = {1'b0, r_score} + (SCOREW+1)'(w_pop);
  assign w_sat = w_sum[SCOREW] ? '1 : w_sum[SCOREW-1:0];
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE, OVER: if (w_press) w_nxt = PLAY;
      PLAY:       if (collide) w_nxt = DYING;
      DYING:      if (frame && r_cnt == CW'(DEATH_FRAMES - 1)) w_nxt = OVER;
    endcase
  end
  assign w_go  = w_nxt == PLAY && r_state != PLAY;
  assign w_die = r_state == PLAY && collide;
  always_ff @(posedge clk_pix or negedge rst_n)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_start_q <= 1'b0;
      r_arm     <= 1'b0;
      r_play    <= 1'b0;
      r_dead    <= 1'b0;
      r_score   <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_nxt;
      r_start_q <= start;
      r_arm     <= r_arm | ~start;
      r_play    <= w_nxt == PLAY;
      r_dead    <= w_nxt[1];
      if (w_go) r_score <= '0;
      else if (r_state == PLAY) r_score <= w_sat;
      if (w_die) r_cnt <= '0;
      else if (r_state == DYING && frame) r_cnt <= r_cnt + 1'b1;
    end
  assign state = r_state;
  assign play  = r_play;
  assign dead  = r_dead;
  assign score = r_score;
`ifdef SF_HISCORE_EN
  logic [SCOREW-1:0] r_hi;
  logic              r_new_hi;
  always_ff @(posedge clk_pix or negedge rst_n)
    if (!rst_n) begin
      r_hi     <= '0;
      r_new_hi <= 1'b0;
    end else if (w_die && w_sat > r_hi) begin
      r_hi     <= w_sat;
      r_new_hi <= 1'b1;
    end else if (w_go) r_new_hi <= 1'b0;
  assign hiscore = r_hi;
  assign new_hi  = r_new_hi;
`else
  assign hiscore = '0;
  assign new_hi  = 1'b0;
`endif
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed scoreboard bench for game_ctrl (hiscore checks follow SF_HISCORE_EN).
module tb_game_ctrl;
`ifdef SF_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif
  typedef struct {
    logic [1:0] st;
    logic [7:0] sc;
    logic [7:0] hi;
    logic       nh;
  } exp_t;
  logic       clk_pix = 1'b0;
  logic       rst_n, frame, start, collide;
  logic [4:0] land;
  logic [1:0] state;
  logic       play, dead, new_hi;
  logic [7:0] score, hiscore;
  exp_t       q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  game_ctrl dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .start(start), .collide(collide),
    .land(land), .state(state), .play(play), .dead(dead), .score(score),
    .hiscore(hiscore), .new_hi(new_hi)
  );
  always #5 clk_pix = ~clk_pix;
  function automatic logic [7:0] hx(input logic [7:0] v);
    return HI_EN ? v : 8'd0;
  endfunction
  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask
  task automatic push(input logic [1:0] st, input logic [7:0] sc, input logic [7:0] hi, input logic nh);
    exp_t e;
    e.st = st;
    e.sc = sc;
    e.hi = hx(hi);
    e.nh = HI_EN & nh;
    q.push_back(e);
  endtask
  task automatic chk(input string tag);
    exp_t e;
    e = q.pop_front();
    cmp({tag, ".state"}, {6'd0, state}, {6'd0, e.st});
    cmp({tag, ".play"}, {7'd0, play}, {7'd0, e.st == 2'd1});
    cmp({tag, ".dead"}, {7'd0, dead}, {7'd0, e.st[1]});
    cmp({tag, ".score"}, score, e.sc);
    cmp({tag, ".hiscore"}, hiscore, e.hi);
    cmp({tag, ".new_hi"}, {7'd0, new_hi}, {7'd0, e.nh});
  endtask
  task automatic step(input string tag, input logic f, input logic s, input logic c, input logic [4:0] l,
                      input logic [1:0] st, input logic [7:0] sc, input logic [7:0] hi, input logic nh);
    push(st, sc, hi, nh);
    @(negedge clk_pix);
    frame = f;
    start = s;
    collide = c;
    land = l;
    @(posedge clk_pix);
    #1;
    chk(tag);
  endtask
  task automatic frames(input string tag, input int n, input logic [7:0] sc, input logic [7:0] hi, input logic nh);
    for (int k = 1; k <= n; k++) begin
      step(tag, 1'b1, 1'b1, 1'b1, 5'b11111, (k == 120) ? 2'd3 : 2'd2, sc, hi, nh);
      step(tag, 1'b0, 1'b1, 1'b0, 5'b00000, (k == 120) ? 2'd3 : 2'd2, sc, hi, nh);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    frame = 1'b0;
    start = 1'b1;
    collide = 1'b0;
    land = '0;
    #3;
    push(2'd0, 8'd0, 8'd0, 1'b0);
    chk("reset");
    @(negedge clk_pix);
    rst_n = 1'b1;
    step("held_after_rst", 0, 1, 0, 5'b00000, 2'd0, 8'd0, 8'd0, 0);
    step("idle_low", 0, 0, 0, 5'b00000, 2'd0, 8'd0, 8'd0, 0);
    step("press", 0, 1, 0, 5'b00000, 2'd1, 8'd0, 8'd0, 0);
    step("land10101", 0, 1, 0, 5'b10101, 2'd1, 8'd3, 8'd0, 0);
    step("land00001", 0, 1, 0, 5'b00001, 2'd1, 8'd4, 8'd0, 0);
    step("land00111", 0, 1, 0, 5'b00111, 2'd1, 8'd7, 8'd0, 0);
    step("collide_land", 0, 1, 1, 5'b00001, 2'd2, 8'd8, 8'd8, 1);
    step("dying_ignore", 0, 1, 1, 5'b11111, 2'd2, 8'd8, 8'd8, 1);
    frames("death1", 120, 8'd8, 8'd8, 1);
    step("over_held", 0, 1, 1, 5'b11111, 2'd3, 8'd8, 8'd8, 1);
    step("over_release", 0, 0, 0, 5'b00000, 2'd3, 8'd8, 8'd8, 1);
    step("over_press", 0, 1, 0, 5'b00000, 2'd1, 8'd0, 8'd8, 0);
    step("g2_land", 0, 1, 0, 5'b00011, 2'd1, 8'd2, 8'd8, 0);
    step("g2_land2", 0, 1, 0, 5'b00111, 2'd1, 8'd5, 8'd8, 0);
    step("g2_collide", 0, 1, 1, 5'b00000, 2'd2, 8'd5, 8'd8, 0);
    frames("death2", 120, 8'd5, 8'd8, 0);
    step("g3_release", 0, 0, 0, 5'b00000, 2'd3, 8'd5, 8'd8, 0);
    step("g3_press", 0, 1, 0, 5'b00000, 2'd1, 8'd0, 8'd8, 0);
    for (int k = 1; k <= 50; k++) step("g3_ramp", 0, 1, 0, 5'b11111, 2'd1, 8'(5 * k), 8'd8, 0);
    step("to254", 0, 1, 0, 5'b01111, 2'd1, 8'd254, 8'd8, 0);
    step("sat255", 0, 1, 0, 5'b00011, 2'd1, 8'd255, 8'd8, 0);
    step("sat_hold", 0, 1, 0, 5'b11111, 2'd1, 8'd255, 8'd8, 0);
    step("g3_collide", 0, 1, 1, 5'b11111, 2'd2, 8'd255, 8'd255, 1);
    frames("death3", 60, 8'd255, 8'd255, 1);
    #2;
    rst_n = 1'b0;
    #1;
    push(2'd0, 8'd0, 8'd0, 1'b0);
    chk("async_rst");
    @(negedge clk_pix);
    rst_n = 1'b1;
    step("post_rst_held", 0, 1, 0, 5'b00000, 2'd0, 8'd0, 8'd0, 0);
    step("post_rst_low", 0, 0, 0, 5'b00000, 2'd0, 8'd0, 8'd0, 0);
    step("post_rst_press", 0, 1, 0, 5'b00001, 2'd1, 8'd0, 8'd0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter SPR_CNT, default 5: number of meteor land inputs.
REQ-002 SHALL have parameter SCOREW, default 8: score width in bits.
REQ-003 SHALL have parameter DEATH_FRAMES, default 120: frames spent in DYING.
REQ-004 SHALL have port clk_pix  input  1  pixel clock, the only clock.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have port frame  input  1  one-cycle pulse at the start of each frame.
REQ-007 SHALL have port start  input  1  debounced start-button level.
REQ-008 SHALL have port collide  input  1  frog/obstacle overlap; a level, sampled every cycle.
REQ-009 SHALL have port land  input  SPR_CNT  per-meteor one-cycle pulse when the meteor wraps back to the top.
REQ-010 SHALL have port state  output  2  IDLE=0, PLAY=1, DYING=2, OVER=3.
REQ-011 SHALL have port play  output  1  high only in PLAY; enables sprite motion.
REQ-012 SHALL have port dead  output  1  high in DYING and OVER.
REQ-013 SHALL have port score  output  SCOREW  current score.
REQ-014 SHALL have port hiscore  output  SCOREW  best score since reset.
REQ-015 SHALL have port new_hi  output  1  high while the last game's score set a new hiscore.

Function
REQ-016 SHALL register all outputs; each output reflects an input event on the clock edge after that event.
REQ-017 SHALL detect a start press as the rising edge of start (start high now, low the previous cycle); a held level SHALL NOT retrigger.
REQ-018 IDLE: on a start press, the block SHALL go to PLAY, clear score to 0 and clear new_hi.
REQ-019 PLAY: each cycle, score SHALL increase by the popcount of land.
REQ-020 The score addition SHALL saturate at 2^SCOREW-1 (255 with default SCOREW); it SHALL never wrap.
REQ-021 PLAY: collide high SHALL move the block to DYING; land pulses in that same cycle SHALL still be counted.
REQ-022 On the PLAY->DYING transition, the frame counter SHALL clear to 0.
REQ-023 DYING: the frame counter SHALL increment on each frame pulse.
REQ-024 DYING: when the counter reaches DEATH_FRAMES-1 and a frame pulse arrives, the block SHALL go to OVER.
REQ-025 DYING: land, collide and start SHALL be ignored.
REQ-026 OVER: on a start press, the block SHALL go to PLAY, clear score to 0 and clear new_hi; collide and land SHALL be ignored.
REQ-027 In states other than PLAY, score SHALL hold its value.
REQ-028 The frame counter SHALL be wide enough for DEATH_FRAMES, i.e. $clog2(DEATH_FRAMES+1) bits.
REQ-029 A start press in the same cycle as an IDLE->PLAY or OVER->PLAY transition SHALL have no further effect.

Reset
REQ-030 While rst_n is low, the block SHALL asynchronously force: state=IDLE, play=0, dead=0, score=0, hiscore=0, new_hi=0, frame counter=0, start edge register=0.
REQ-031 A reset asserted in any state, including mid-DYING, SHALL abort immediately and lose hiscore.
REQ-032 After rst_n rises, the first start press SHALL be accepted only once start has been sampled low for at least one cycle.

Configuration
REQ-033 The hiscore feature SHALL be compiled in or out with the macro SF_HISCORE_EN.
REQ-034 With SF_HISCORE_EN defined: on the PLAY->DYING transition, if the final score (including same-cycle lands) is strictly greater than hiscore, hiscore SHALL load that score and new_hi SHALL go high.
REQ-035 With SF_HISCORE_EN undefined: hiscore and new_hi SHALL be tied to 0 and no hiscore register SHALL be synthesised.

Verification
REQ-036 Reset, then start pulse -> state=1 and play=1 one cycle after the edge; score=0.
REQ-037 In PLAY, land=5'b10101 for one cycle, then land=5'b00001 -> score=3, then score=4.
REQ-038 Score=254, land=5'b00011 -> score=255; a further land=5'b11111 -> score stays 255.
REQ-039 Score=7 with collide and land=5'b00001 in the same cycle -> state=2, score=8, hiscore=8, new_hi=1; state=3 after exactly 120 frame pulses.
REQ-040 In OVER: start held high from the previous game -> no transition; release then press -> state=1, score=0, new_hi=0, hiscore still 8. Next game ends at score 5 -> hiscore stays 8, new_hi=0.
REQ-041 rst_n pulsed low at frame 60 of DYING -> all outputs 0 and state=0 asynchronously. Repeat with SF_HISCORE_EN undefined -> hiscore=0 and new_hi=0 throughout.
